// File: rtl/cla_sub_pipe_pkg.sv
// Shared definitions for the pipelined carry-lookahead subtractor:
// default width, signed saturation limits and the stage 1 register layout.
package cla_sub_pipe_pkg;

    localparam int CLA_WIDTH = 16;
    localparam int CLA_HALF  = CLA_WIDTH / 2;

    // Largest positive and most negative two's-complement values at CLA_WIDTH.
    localparam logic [CLA_WIDTH-1:0] SAT_MAX = {1'b0, {(CLA_WIDTH-1){1'b1}}};
    localparam logic [CLA_WIDTH-1:0] SAT_MIN = {1'b1, {(CLA_WIDTH-1){1'b0}}};

    // Stage 1 register: finished low half plus the operands the high half still needs.
    typedef struct packed {
        logic [CLA_HALF-1:0] lo_diff;
        logic                c_lo;
        logic [CLA_HALF-1:0] a_hi;
        logic [CLA_HALF-1:0] nb_hi;
    } s1_t;

    // Clamp value for an overflowing difference: a negative minuend can only
    // overflow downwards, a non-negative one only upwards.
    function automatic logic [CLA_WIDTH-1:0] sat_value(input logic a_neg);
        logic [CLA_WIDTH-1:0] v;
        if (a_neg) begin
            v = SAT_MIN;
        end else begin
            v = SAT_MAX;
        end
        return v;
    endfunction

endpackage

// File: rtl/cla_nibble_group.sv
// 4-bit carry-lookahead group: sum, carry-out and group propagate/generate.
module cla_nibble_group (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       p,
    output logic       g
);

    logic [3:0] gen_s;
    logic [3:0] prp_s;
    logic [3:0] c_s;

    // Bit generate/propagate and fully expanded lookahead carries inside the group.
    always_comb begin
        gen_s  = x & y;
        prp_s  = x ^ y;
        c_s[0] = cin;
        c_s[1] = gen_s[0] | (prp_s[0] & cin);
        c_s[2] = gen_s[1] | (prp_s[1] & gen_s[0]) | (prp_s[1] & prp_s[0] & cin);
        c_s[3] = gen_s[2] | (prp_s[2] & gen_s[1]) | (prp_s[2] & prp_s[1] & gen_s[0])
               | (prp_s[2] & prp_s[1] & prp_s[0] & cin);
        p      = &prp_s;
        g      = gen_s[3] | (prp_s[3] & gen_s[2]) | (prp_s[3] & prp_s[2] & gen_s[1])
               | (prp_s[3] & prp_s[2] & prp_s[1] & gen_s[0]);
        cout   = g | (p & cin);
        s      = prp_s ^ c_s;
    end

endmodule

// File: rtl/cla_sub_pipe.sv
// Two-stage pipelined two's-complement subtractor (diff = a + ~b + 1) with
// valid/ready on both sides; low half in stage 1, high half plus flags in stage 2.
module cla_sub_pipe
    import cla_sub_pipe_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int HALF = WIDTH / 2;
    localparam int NGRP = HALF / 4;

    logic             adv1_s, adv2_s, in_ready_s;
    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    s1_t              s1_q, s1_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d, ovf_q, ovf_d;
    logic             a_msb_s, b_msb_s, ovf_raw_s;

    logic [HALF-1:0]  nb_lo_s, lo_sum_s, hi_sum_s;
    logic [NGRP:0]    lo_c_s, hi_c_s;
    logic [NGRP-1:0]  lo_p_s, lo_g_s, hi_p_s, hi_g_s;
    logic             unused_pg_s;

    assign nb_lo_s   = ~b[HALF-1:0];
    assign lo_c_s[0] = 1'b1;          // the +1 of two's-complement negation
    assign hi_c_s[0] = s1_q.c_lo;     // carry handed over from stage 1

    // Group P/G are exposed for wider lookahead trees; here groups chain by carry-out.
    assign unused_pg_s = ^{lo_p_s, lo_g_s, hi_p_s, hi_g_s};

    for (genvar gi = 0; gi < NGRP; gi++) begin : g_lo
        cla_nibble_group u_grp (
            .x    (a[gi*4 +: 4]),
            .y    (nb_lo_s[gi*4 +: 4]),
            .cin  (lo_c_s[gi]),
            .s    (lo_sum_s[gi*4 +: 4]),
            .cout (lo_c_s[gi+1]),
            .p    (lo_p_s[gi]),
            .g    (lo_g_s[gi])
        );
    end

    for (genvar gi = 0; gi < NGRP; gi++) begin : g_hi
        cla_nibble_group u_grp (
            .x    (s1_q.a_hi[gi*4 +: 4]),
            .y    (s1_q.nb_hi[gi*4 +: 4]),
            .cin  (hi_c_s[gi]),
            .s    (hi_sum_s[gi*4 +: 4]),
            .cout (hi_c_s[gi+1]),
            .p    (hi_p_s[gi]),
            .g    (hi_g_s[gi])
        );
    end

    // Handshake and stage advance; in_ready depends on out_ready but never on in_valid.
    always_comb begin
        adv2_s     = s1_valid_q & (~s2_valid_q | out_ready);
        in_ready_s = ~s1_valid_q | adv2_s;
        adv1_s     = in_valid & in_ready_s;
        s1_valid_d = adv1_s | (s1_valid_q & ~adv2_s);
        s2_valid_d = adv2_s | (s2_valid_q & ~out_ready);
    end

    // Stage 1 next state: capture low-half result and high-half operands on accept.
    always_comb begin
        s1_d = s1_q;
        if (adv1_s) begin
            s1_d.lo_diff = lo_sum_s;
            s1_d.c_lo    = lo_c_s[NGRP];
            s1_d.a_hi    = a[WIDTH-1:HALF];
            s1_d.nb_hi   = ~b[WIDTH-1:HALF];
        end else begin
            s1_d = s1_q;
        end
    end

    // Stage 2 next state: finish high half, derive borrow/overflow, optionally clamp.
    always_comb begin
        a_msb_s   = s1_q.a_hi[HALF-1];
        b_msb_s   = ~s1_q.nb_hi[HALF-1];
        ovf_raw_s = (a_msb_s ^ b_msb_s) & (hi_sum_s[HALF-1] ^ a_msb_s);
        diff_d    = diff_q;
        borrow_d  = borrow_q;
        ovf_d     = ovf_q;
        if (adv2_s) begin
            borrow_d = ~hi_c_s[NGRP];
            ovf_d    = ovf_raw_s;
            if (SAT && ovf_raw_s) begin
                diff_d = sat_value(a_msb_s);
            end else begin
                diff_d = {hi_sum_s, s1_q.lo_diff};
            end
        end else begin
            diff_d   = diff_q;
            borrow_d = borrow_q;
            ovf_d    = ovf_q;
        end
    end

    // Pipeline registers; reset drops any in-flight operands immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            ovf_q      <= ovf_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Self-checking bench for cla_sub_pipe: a saturating and a wrapping instance
// share stimulus; results are checked against an arithmetic reference in a FIFO scoreboard.
module tb_cla_sub_pipe;

    logic        clk, rst_n, in_valid, out_ready;
    logic [15:0] a, b;
    logic        in_ready_sat, in_ready_wrap, out_valid_sat, out_valid_wrap;
    logic [15:0] diff_sat, diff_wrap;
    logic        borrow_sat, borrow_wrap, ovf_sat, ovf_wrap;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit lat_chk  = 1'b0;

    typedef struct packed {
        logic [15:0] dsat;
        logic [15:0] dwrap;
        logic        br;
        logic        ov;
        logic [31:0] acc;
    } exp_t;

    exp_t sb_q[$];

    cla_sub_pipe #(.WIDTH(16), .SAT(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_sat),
        .a(a), .b(b), .out_valid(out_valid_sat), .out_ready(out_ready),
        .diff(diff_sat), .borrow(borrow_sat), .ovf(ovf_sat)
    );

    cla_sub_pipe #(.WIDTH(16), .SAT(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_wrap),
        .a(a), .b(b), .out_valid(out_valid_wrap), .out_ready(out_ready),
        .diff(diff_wrap), .borrow(borrow_wrap), .ovf(ovf_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: plain integer subtraction and range test.
    function automatic exp_t ref_model(input logic [15:0] x, input logic [15:0] y, input int c);
        exp_t e;
        int   sx, sy, sd;
        sx      = int'(signed'(x));
        sy      = int'(signed'(y));
        sd      = sx - sy;
        e.ov    = (sd > 32767) || (sd < -32768);
        e.br    = (x < y);
        e.dwrap = x - y;
        e.dsat  = e.ov ? ((sd > 0) ? 16'h7FFF : 16'h8000) : e.dwrap;
        e.acc   = c;
        return e;
    endfunction

    function automatic logic [15:0] pick_operand();
        logic [15:0] corners [5];
        logic [15:0] v;
        corners[0] = 16'h0000; corners[1] = 16'h0001; corners[2] = 16'h7FFF;
        corners[3] = 16'h8000; corners[4] = 16'hFFFF;
        if ($urandom_range(0, 3) == 0) begin
            v = corners[$urandom_range(0, 4)];
        end else begin
            v = 16'($urandom);
        end
        return v;
    endfunction

    // One clock cycle: drive after the falling edge, then observe what the next rising edge transfers.
    task automatic cycle(input logic v, input logic [15:0] av, input logic [15:0] bv,
                         input logic ordy, output logic acc, output logic ot);
        exp_t e;
        @(negedge clk);
        cyc++;
        in_valid  = v;
        a         = av;
        b         = bv;
        out_ready = ordy;
        #1;
        check("in_ready_pair", 32'(in_ready_wrap), 32'(in_ready_sat));
        check("out_valid_pair", 32'(out_valid_wrap), 32'(out_valid_sat));
        ot = out_valid_sat && out_ready;
        if (ot) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output_sb_size", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("diff_sat", 32'(diff_sat), 32'(e.dsat));
                check("diff_wrap", 32'(diff_wrap), 32'(e.dwrap));
                check("borrow_sat", 32'(borrow_sat), 32'(e.br));
                check("borrow_wrap", 32'(borrow_wrap), 32'(e.br));
                check("ovf_sat", 32'(ovf_sat), 32'(e.ov));
                check("ovf_wrap", 32'(ovf_wrap), 32'(e.ov));
                if (lat_chk) begin
                    check("latency", 32'(cyc) - e.acc, 32'd2);
                end
            end
        end
        acc = v && in_ready_sat;
        if (acc) begin
            sb_q.push_back(ref_model(av, bv, cyc));
        end
    endtask

    task automatic drain(input string tag);
        logic acc, ot;
        for (int k = 0; k < 10; k++) begin
            if (sb_q.size() != 0) begin
                cycle(1'b0, 16'h0000, 16'h0000, 1'b1, acc, ot);
            end
        end
        check(tag, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        logic        acc, ot, pend, rv, ro;
        logic [15:0] ra, rb;
        int          idx, outs;
        logic [15:0] da [7];
        logic [15:0] db [7];

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 16'h0000; b = 16'h0000;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid_sat), 32'd0);
        check("rst_diff", 32'(diff_sat), 32'd0);
        check("rst_borrow", 32'(borrow_wrap), 32'd0);
        check("rst_ovf", 32'(ovf_sat), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready_sat), 32'd1);

        // Directed vectors back-to-back with out_ready held high: latency must be 2.
        da[0] = 16'h0005; db[0] = 16'h0003;
        da[1] = 16'h0003; db[1] = 16'h0005;
        da[2] = 16'h0100; db[2] = 16'h0001;
        da[3] = 16'h8000; db[3] = 16'h0001;
        da[4] = 16'h7FFF; db[4] = 16'hFFFF;
        da[5] = 16'h0000; db[5] = 16'h0001;
        da[6] = 16'h7FFF; db[6] = 16'h8000;
        lat_chk = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, da[i], db[i], 1'b1, acc, ot);
            check("directed_accept", 32'(acc), 32'd1);
        end
        drain("directed_drain");

        // Back-pressure: out_ready low for three cycles, then four results stream out.
        lat_chk = 1'b0;
        idx  = 0;
        outs = 0;
        for (int k = 0; k < 12; k++) begin
            cycle(idx < 4, 16'(10 * (idx + 1)), 16'(idx + 1), k >= 3, acc, ot);
            if (k == 2) begin
                check("bp_in_ready_low", 32'(in_ready_sat), 32'd0);
                check("bp_two_accepted", 32'(idx), 32'd2);
            end
            if (ot && k >= 3 && k <= 6) outs++;
            if (acc) idx++;
        end
        check("bp_back_to_back", 32'(outs), 32'd4);
        check("bp_all_accepted", 32'(idx), 32'd4);
        drain("bp_drain");

        // Asynchronous reset with both stages occupied.
        cycle(1'b1, 16'h1111, 16'h0001, 1'b0, acc, ot);
        cycle(1'b1, 16'h2222, 16'h0002, 1'b0, acc, ot);
        cycle(1'b0, 16'h0000, 16'h0000, 1'b0, acc, ot);
        check("pre_rst_out_valid", 32'(out_valid_sat), 32'd1);
        check("pre_rst_in_ready", 32'(in_ready_sat), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid_sat), 32'd0);
        check("async_rst_diff", 32'(diff_sat), 32'd0);
        check("async_rst_borrow", 32'(borrow_sat), 32'd0);
        check("async_rst_ovf", 32'(ovf_wrap), 32'd0);
        sb_q.delete();
        #1;
        rst_n = 1'b1;
        lat_chk = 1'b1;
        cycle(1'b1, 16'h1234, 16'h0234, 1'b1, acc, ot);
        check("post_rst_accept", 32'(acc), 32'd1);
        drain("post_rst_drain");

        // Randomised traffic with random back-pressure; operands held while stalled.
        lat_chk = 1'b0;
        pend = 1'b0;
        rv = 1'b0; ra = 16'h0000; rb = 16'h0000;
        for (int k = 0; k < 400; k++) begin
            if (!pend) begin
                rv = ($urandom_range(0, 3) != 0);
                ra = pick_operand();
                rb = pick_operand();
            end
            ro = ($urandom_range(0, 3) != 0);
            cycle(rv, ra, rb, ro, acc, ot);
            pend = rv && !acc;
        end
        drain("random_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
